// File: rtl/uart_rx_frontend.sv
// uart_rx_frontend: 8N1 UART receiver with glitch rejection, framing/overrun flags and ready/valid output.
// Define UART_RX_FIFO_EN to replace the single holding register with a 4-entry FIFO.
module uart_rx_frontend #(
    parameter int CLOCK_FREQ = 10_000_000,
    parameter int BAUD_RATE  = 115_200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       serial_in,
    output logic [7:0] data_out,
    output logic       data_out_valid,
    input  logic       data_out_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       rx_busy
);
    localparam int SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE;
    localparam int SAMPLE_TIME = SYMBOL_EDGE_TIME / 2;
    localparam int CW = $clog2(SYMBOL_EDGE_TIME) + 1;
    localparam logic [CW-1:0] SMP = CW'(SAMPLE_TIME - 1);
    localparam logic [CW-1:0] EDGE = CW'(SYMBOL_EDGE_TIME - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

    state_t state_q, state_d;
    logic s1_q, s2_q, rxs;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0] idx_q, idx_d;
    logic [7:0] shreg_q, shreg_d;
    logic [1:0] warm_q, warm_d;
    logic armed_q, armed_d;
    logic fe_q, fe_d, ov_q, ov_d;
    logic smp, push, pop;

    assign rxs = s2_q;
    // The synchronizer reset value is not a real line observation, so wait until the pin itself is seen high.
    assign warm_d = {warm_q[0], 1'b1};
    assign armed_d = armed_q | (warm_q[1] & rxs);

    always_comb begin
        state_d = state_q;
        idx_d = idx_q;
        shreg_d = shreg_q;
        smp = 1'b0;
        push = 1'b0;
        fe_d = 1'b0;
        case (state_q)
            IDLE: state_d = (!rxs && armed_q) ? START : IDLE;
            START: if (cnt_q == SMP) begin
                smp = 1'b1;
                idx_d = 3'd0;
                state_d = rxs ? IDLE : DATA;
            end
            DATA: if (cnt_q == EDGE) begin
                smp = 1'b1;
                shreg_d[idx_q] = rxs;
                idx_d = idx_q + 3'd1;
                state_d = (idx_q == 3'd7) ? STOP : DATA;
            end
            STOP: if (cnt_q == EDGE) begin
                smp = 1'b1;
                push = rxs;
                fe_d = !rxs;
                state_d = rxs ? IDLE : BREAK;
            end
            BREAK: state_d = rxs ? IDLE : BREAK;
            default: state_d = IDLE;
        endcase
        cnt_d = (smp || state_d != state_q) ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= 1'b1;
            s2_q <= 1'b1;
            state_q <= IDLE;
            cnt_q <= '0;
            idx_q <= '0;
            shreg_q <= '0;
            warm_q <= '0;
            armed_q <= 1'b0;
            fe_q <= 1'b0;
            ov_q <= 1'b0;
        end else begin
            s1_q <= serial_in;
            s2_q <= s1_q;
            state_q <= state_d;
            cnt_q <= cnt_d;
            idx_q <= idx_d;
            shreg_q <= shreg_d;
            warm_q <= warm_d;
            armed_q <= armed_d;
            fe_q <= fe_d;
            ov_q <= ov_d;
        end
    end

`ifdef UART_RX_FIFO_EN
    logic [7:0] mem_q [4];
    logic [1:0] wp_q, wp_d, rp_q, rp_d;
    logic [2:0] fcnt_q, fcnt_d;
    logic wr;

    always_comb begin
        pop = (fcnt_q != 3'd0) && data_out_ready;
        wr = push && (fcnt_q != 3'd4 || pop);
        ov_d = push && fcnt_q == 3'd4 && !pop;
        wp_d = wp_q + 2'(wr);
        rp_d = rp_q + 2'(pop);
        fcnt_d = fcnt_q + 3'(wr) - 3'(pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q <= '{default: '0};
            wp_q <= '0;
            rp_q <= '0;
            fcnt_q <= '0;
        end else begin
            if (wr) mem_q[wp_q] <= shreg_q;
            wp_q <= wp_d;
            rp_q <= rp_d;
            fcnt_q <= fcnt_d;
        end
    end

    assign data_out = mem_q[rp_q];
    assign data_out_valid = fcnt_q != 3'd0;
`else
    logic [7:0] data_q, data_d;
    logic valid_q, valid_d;
    logic load;

    always_comb begin
        pop = valid_q && data_out_ready;
        load = push && (!valid_q || pop);
        ov_d = push && valid_q && !pop;
        data_d = load ? shreg_q : data_q;
        valid_d = load || (valid_q && !pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q <= data_d;
            valid_q <= valid_d;
        end
    end

    assign data_out = data_q;
    assign data_out_valid = valid_q;
`endif

    assign frame_err = fe_q;
    assign overrun = ov_q;
    assign rx_busy = state_q != IDLE;
endmodule

// File: tb/tb_uart_rx_frontend.sv
// tb_uart_rx_frontend: directed scoreboard bench for uart_rx_frontend.
module tb_uart_rx_frontend;
    localparam int BIT = 86;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic serial_in = 1'b1;
    logic data_out_ready = 1'b1;
    logic [7:0] data_out;
    logic data_out_valid, frame_err, overrun, rx_busy;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int fe_cnt = 0;
    int ov_cnt = 0;
    int v_cnt = 0;
    int rise_cyc = 0;
    int t_start = 0;
    logic v_prev = 1'b0;
    logic [7:0] got[$];
    logic [7:0] exp_q[$];

    uart_rx_frontend dut (
        .clk(clk),
        .rst(rst),
        .serial_in(serial_in),
        .data_out(data_out),
        .data_out_valid(data_out_valid),
        .data_out_ready(data_out_ready),
        .frame_err(frame_err),
        .overrun(overrun),
        .rx_busy(rx_busy)
    );

    always #50 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (data_out_valid && data_out_ready) got.push_back(data_out);
            if (data_out_valid && !v_prev) rise_cyc <= cyc;
            if (data_out_valid) v_cnt <= v_cnt + 1;
            if (frame_err) fe_cnt <= fe_cnt + 1;
            if (overrun) ov_cnt <= ov_cnt + 1;
        end
        v_prev <= rst ? 1'b0 : data_out_valid;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input logic stop_b);
        t_start = cyc;
        serial_in = 1'b0;
        wait_cyc(BIT);
        for (int i = 0; i < 8; i++) begin
            serial_in = b[i];
            wait_cyc(BIT);
        end
        serial_in = stop_b;
        wait_cyc(BIT);
    endtask

    task automatic drain(input string tag);
        chk({tag, "_count"}, got.size(), exp_q.size());
        while (got.size() != 0 && exp_q.size() != 0) chk(tag, got.pop_front(), exp_q.pop_front());
        got.delete();
        exp_q.delete();
    endtask

    initial begin
        int fe0, ov0, v0;
        wait_cyc(3);
        chk("rst_data", data_out, 8'h00);
        chk("rst_valid", data_out_valid, 1'b0);
        chk("rst_fe", frame_err, 1'b0);
        chk("rst_ov", overrun, 1'b0);
        chk("rst_busy", rx_busy, 1'b0);
        rst = 1'b0;
        wait_cyc(5);

        fe0 = fe_cnt;
        exp_q.push_back(8'h61);
        send(8'h61, 1'b1);
        chk("basic_latency_ok", (rise_cyc - t_start >= 818) && (rise_cyc - t_start <= 822), 1'b1);
        drain("basic");
        chk("basic_fe", fe_cnt - fe0, 0);

        v0 = v_cnt;
        serial_in = 1'b0;
        wait_cyc(20);
        serial_in = 1'b1;
        wait_cyc(30);
        chk("glitch_busy", rx_busy, 1'b0);
        chk("glitch_valid", v_cnt - v0, 0);
        exp_q.push_back(8'h62);
        send(8'h62, 1'b1);
        drain("after_glitch");

        fe0 = fe_cnt;
        v0 = v_cnt;
        send(8'h55, 1'b0);
        wait_cyc(200);
        serial_in = 1'b1;
        wait_cyc(10);
        chk("frame_err_pulses", fe_cnt - fe0, 1);
        chk("frame_no_valid", v_cnt - v0, 0);
        chk("break_exit_busy", rx_busy, 1'b0);
        exp_q.push_back(8'h63);
        send(8'h63, 1'b1);
        drain("after_frame");

        ov0 = ov_cnt;
        data_out_ready = 1'b0;
`ifdef UART_RX_FIFO_EN
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(8'h61 + 8'(i));
            send(8'h61 + 8'(i), 1'b1);
        end
        chk("fifo_no_ov", ov_cnt - ov0, 0);
        send(8'h65, 1'b1);
        chk("fifo_ov", ov_cnt - ov0, 1);
        chk("fifo_head", data_out, 8'h61);
        data_out_ready = 1'b1;
        wait_cyc(6);
        chk("fifo_empty", data_out_valid, 1'b0);
        drain("fifo_pop");
`else
        send(8'h61, 1'b1);
        send(8'h62, 1'b1);
        wait_cyc(5);
        chk("ov_pulses", ov_cnt - ov0, 1);
        chk("ov_hold_data", data_out, 8'h61);
        chk("ov_hold_valid", data_out_valid, 1'b1);
        exp_q.push_back(8'h61);
        data_out_ready = 1'b1;
        wait_cyc(1);
        chk("ov_popped_valid", data_out_valid, 1'b0);
        drain("ov_pop");
`endif

        fe0 = fe_cnt;
        ov0 = ov_cnt;
        for (int i = 0; i < 10; i++) begin
            exp_q.push_back(8'h61 + 8'(i));
            send(8'h61 + 8'(i), 1'b1);
        end
        wait_cyc(5);
        drain("stream");
        chk("stream_fe", fe_cnt - fe0, 0);
        chk("stream_ov", ov_cnt - ov0, 0);

        v0 = v_cnt;
        fork
            send(8'hF5, 1'b1);
            begin
                wait_cyc(BIT * 5 + 43);
                rst = 1'b1;
                wait_cyc(1);
                chk("mid_rst_data", data_out, 8'h00);
                chk("mid_rst_valid", data_out_valid, 1'b0);
                chk("mid_rst_busy", rx_busy, 1'b0);
                chk("mid_rst_fe", frame_err, 1'b0);
                chk("mid_rst_ov", overrun, 1'b0);
                rst = 1'b0;
            end
        join
        wait_cyc(20);
        chk("mid_rst_no_byte", v_cnt - v0, 0);
        exp_q.push_back(8'h6B);
        send(8'h6B, 1'b1);
        drain("after_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
